nand2_sweep_ctrl: RTL and testbench
===================================

Name: nand2_sweep_ctrl

Overview:
- Self-test sequencer for a bitwise 2-input NAND gate under test (GUT).
- On start, walks every input combination, holds each vector for a settle window, samples the GUT output and checks it against ~(in1 & in0).
- Reports a mismatch count, the first failing vector and pass/fail.
- Sits between a gate instance and a top-level bench or board harness. It replaces hand-written delay-driven stimulus with a clocked, self-checking sweep.

Parameters:
- WIDTH, 1, bit width of each GUT operand; legal range 1..4.
- SETTLE_CYCLES, 2, number of wait cycles between driving a vector and sampling; legal range 0..15.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-high reset.
- start  input  1  single-cycle or level request to begin a sweep; honoured only in IDLE or DONE.
- gate_in1  output  WIDTH  operand 1 to GUT; registered.
- gate_in0  output  WIDTH  operand 0 to GUT; registered.
- gate_out  input  WIDTH  GUT output.
- busy  output  1  high from the DRIVE of vector 0 through the last SAMPLE.
- done  output  1  sweep complete; level, held until next start or reset.
- pass  output  1  valid while done; 1 iff err_count == 0.
- err_count  output  8  mismatching vectors; saturates at 255.
- first_err_vec  output  2*WIDTH  vector {in1,in0} of the first mismatch.
- first_err_valid  output  1  first_err_vec holds a captured value.

Behaviour:
- Reset, asynchronous: state = IDLE. All outputs are 0: gate_in1, gate_in0, busy, done, pass, err_count, first_err_vec, first_err_valid. The vector counter and settle counter are also 0.
- Vector counter vec is 2*WIDTH bits wide. gate_in1 = vec[2W-1:W] and gate_in0 = vec[W-1:0]. Sweep order is vec = 0, 1, …, 2^(2W)-1.
- States: IDLE, DRIVE, SETTLE, SAMPLE, DONE.
- IDLE/DONE:
  - start=1 moves to DRIVE.
  - On that same edge: vec←0; err_count, first_err_valid, first_err_vec, done and pass are cleared; busy←1.
  - start=0 keeps the current state.
  - Outputs in DONE are frozen.
- DRIVE, 1 cycle:
  - gate_in1/gate_in0 are loaded from vec on entry and held constant through SAMPLE.
  - settle counter ← SETTLE_CYCLES.
  - Next state is SETTLE if SETTLE_CYCLES > 0, else SAMPLE.
- SETTLE:
  - The counter decrements each cycle.
  - When it reaches 1, move to SAMPLE.
  - This gives exactly SETTLE_CYCLES cycles in SETTLE.
- SAMPLE, 1 cycle:
  - expected = ~(gate_in1 & gate_in0).
  - If gate_out != expected, it is a mismatch:
    - err_count increments, but holds at 255.
    - If first_err_valid=0, capture first_err_vec ← vec and set first_err_valid←1.
  - If vec = all-ones: go to DONE; busy←0, done←1, pass ← (updated err_count == 0).
  - Otherwise: vec←vec+1 and go to DRIVE.
- Latency per vector = SETTLE_CYCLES + 2 cycles.
- Full sweep: done rises 2^(2W)·(SETTLE_CYCLES+2) cycles after the start edge.
- start while busy (DRIVE/SETTLE/SAMPLE) is ignored and has no effect on sequence or counters.
- A mismatch on the last vector is counted before pass is evaluated, in the same edge.
- gate_out is sampled only in SAMPLE; X/Z on gate_out in other states is ignored.
- Reset mid-sweep returns to IDLE immediately. Results are cleared, and a new start begins at vec 0.
- The design is fully synchronous except reset, and has no combinational path from gate_out to any output.

Test Plan:
- Correct NAND model, WIDTH=1, SETTLE_CYCLES=2, 1-cycle start pulse → vectors 00, 01, 10, 11 each held 4 cycles. done rises 16 cycles after start; pass=1, err_count=0, first_err_valid=0.
- GUT output stuck-at-1, WIDTH=1 → only vec 3 mismatches. Result: err_count=1, first_err_vec=2'b11, first_err_valid=1, pass=0.
- GUT replaced by AND, WIDTH=1 → all 4 vectors mismatch. Result: err_count=4, first_err_vec=2'b00, pass=0.
- WIDTH=4, SETTLE_CYCLES=0, GUT = AND → 256 vectors, 2 cycles each; done at cycle 512. err_count saturates at 255, first_err_vec=8'h00.
- start pulsed during SETTLE of vec 2 → sequence, timing and counts are identical to the undisturbed run. Then start in DONE → a fresh sweep begins and done/pass/err_count are cleared on that edge.
- reset asserted asynchronously in the middle of SAMPLE of vec 1 → all outputs are 0 immediately. After reset is released, start runs a clean sweep beginning at vec 0 with correct results.

Source files
------------

// File: rtl/nand2_sweep_ctrl.sv
// nand2_sweep_ctrl
// Self-test sequencer for a bitwise 2-input NAND gate under test (GUT).
// On start it walks every {in1,in0} combination in ascending order. Each
// vector is driven for one cycle, held for SETTLE_CYCLES wait cycles and
// then sampled once. The sampled GUT output is checked against ~(in1 & in0).
//
// Ports:
//   clk             rising-edge system clock
//   reset           asynchronous, active-high reset
//   start           sweep request, honoured only in IDLE or DONE
//   gate_in1/0      registered operands driven to the GUT
//   gate_out        GUT output, looked at only in SAMPLE
//   busy            high from DRIVE of vector 0 through the last SAMPLE
//   done            sweep complete, held until the next start or reset
//   pass            valid while done, 1 iff no vector mismatched
//   err_count       mismatching vectors, saturating at 255
//   first_err_vec   {in1,in0} of the first mismatching vector
//   first_err_valid first_err_vec holds a captured value
module nand2_sweep_ctrl #(
  parameter int WIDTH         = 1,
  parameter int SETTLE_CYCLES = 2
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  output logic [WIDTH-1:0]   gate_in1,
  output logic [WIDTH-1:0]   gate_in0,
  input  logic [WIDTH-1:0]   gate_out,
  output logic               busy,
  output logic               done,
  output logic               pass,
  output logic [7:0]         err_count,
  output logic [2*WIDTH-1:0] first_err_vec,
  output logic               first_err_valid
);

  localparam int VW = 2 * WIDTH;

  typedef enum logic [2:0] {
    IDLE,
    DRIVE,
    SETTLE,
    SAMPLE,
    DONE
  } state_t;

  state_t          state_q, state_d;
  logic [VW-1:0]   vec_q, vec_d;
  logic [3:0]      settle_q, settle_d;
  logic [WIDTH-1:0] gate_in1_q, gate_in1_d;
  logic [WIDTH-1:0] gate_in0_q, gate_in0_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;
  logic            pass_q, pass_d;
  logic [7:0]      err_count_q, err_count_d;
  logic [VW-1:0]   first_err_vec_q, first_err_vec_d;
  logic            first_err_valid_q, first_err_valid_d;

  logic [WIDTH-1:0] expected;
  logic             mismatch;
  logic [7:0]       err_inc;

  // Next-state and next-output logic. The operand registers are loaded with
  // the vector in the same edge that enters DRIVE, so the GUT sees a vector
  // for the whole DRIVE..SAMPLE window. pass is derived from err_count_d so
  // a mismatch on the last vector is already counted when pass is decided.
  always_comb begin
    state_d           = state_q;
    vec_d             = vec_q;
    settle_d          = settle_q;
    gate_in1_d        = gate_in1_q;
    gate_in0_d        = gate_in0_q;
    busy_d            = busy_q;
    done_d            = done_q;
    pass_d            = pass_q;
    err_count_d       = err_count_q;
    first_err_vec_d   = first_err_vec_q;
    first_err_valid_d = first_err_valid_q;

    expected = ~(gate_in1_q & gate_in0_q);
    mismatch = (gate_out != expected);
    err_inc  = (err_count_q == 8'hFF) ? err_count_q : err_count_q + 8'd1;

    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          state_d           = DRIVE;
          vec_d             = '0;
          gate_in1_d        = '0;
          gate_in0_d        = '0;
          err_count_d       = 8'd0;
          first_err_vec_d   = '0;
          first_err_valid_d = 1'b0;
          done_d            = 1'b0;
          pass_d            = 1'b0;
          busy_d            = 1'b1;
        end
      end
      DRIVE: begin
        settle_d = 4'(SETTLE_CYCLES);
        state_d  = (SETTLE_CYCLES > 0) ? SETTLE : SAMPLE;
      end
      SETTLE: begin
        // Entered with SETTLE_CYCLES, leaves when the count is 1, so the
        // state is occupied for exactly SETTLE_CYCLES cycles.
        settle_d = settle_q - 4'd1;
        if (settle_q <= 4'd1) begin
          state_d = SAMPLE;
        end
      end
      SAMPLE: begin
        if (mismatch) begin
          err_count_d = err_inc;
          if (!first_err_valid_q) begin
            first_err_vec_d   = vec_q;
            first_err_valid_d = 1'b1;
          end
        end
        if (vec_q == '1) begin
          state_d = DONE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          pass_d  = (err_count_d == 8'd0);
        end else begin
          vec_d      = vec_q + VW'(1);
          gate_in1_d = vec_d[VW-1:WIDTH];
          gate_in0_d = vec_d[WIDTH-1:0];
          state_d    = DRIVE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and output registers, cleared asynchronously by reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q           <= IDLE;
      vec_q             <= '0;
      settle_q          <= 4'd0;
      gate_in1_q        <= '0;
      gate_in0_q        <= '0;
      busy_q            <= 1'b0;
      done_q            <= 1'b0;
      pass_q            <= 1'b0;
      err_count_q       <= 8'd0;
      first_err_vec_q   <= '0;
      first_err_valid_q <= 1'b0;
    end else begin
      state_q           <= state_d;
      vec_q             <= vec_d;
      settle_q          <= settle_d;
      gate_in1_q        <= gate_in1_d;
      gate_in0_q        <= gate_in0_d;
      busy_q            <= busy_d;
      done_q            <= done_d;
      pass_q            <= pass_d;
      err_count_q       <= err_count_d;
      first_err_vec_q   <= first_err_vec_d;
      first_err_valid_q <= first_err_valid_d;
    end
  end

  assign gate_in1        = gate_in1_q;
  assign gate_in0        = gate_in0_q;
  assign busy            = busy_q;
  assign done            = done_q;
  assign pass            = pass_q;
  assign err_count       = err_count_q;
  assign first_err_vec   = first_err_vec_q;
  assign first_err_valid = first_err_valid_q;

endmodule

// File: tb/tb_nand2_sweep_ctrl.sv
// tb_nand2_sweep_ctrl
// Self-checking bench for nand2_sweep_ctrl. Two instances are exercised:
// a narrow one (WIDTH=1, SETTLE_CYCLES=2) and a wide one (WIDTH=4,
// SETTLE_CYCLES=0). Each GUT is a behavioural gate whose behaviour is
// chosen per sweep: correct NAND, stuck-at-1, AND, or NAND with random
// per-vector bit flips. Expected results come from a reference model that
// enumerates every vector and applies the sweep rules directly.
module tb_nand2_sweep_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset;
  logic start_a, start_b;

  // Narrow instance
  logic [0:0] a_in1, a_in0, a_out;
  logic       a_busy, a_done, a_pass, a_fvalid;
  logic [7:0] a_err;
  logic [1:0] a_fvec;

  // Wide instance
  logic [3:0] b_in1, b_in0, b_out;
  logic       b_busy, b_done, b_pass, b_fvalid;
  logic [7:0] b_err;
  logic [7:0] b_fvec;

  int mode_a, mode_b;
  logic [0:0] flip_a [4];
  logic [3:0] flip_b [256];

  int checks   = 0;
  int failures = 0;

  // Snapshot of the selected instance's outputs
  logic [7:0] o_vec, o_err, o_fvec;
  logic       o_busy, o_done, o_pass, o_fvalid;

  nand2_sweep_ctrl #(.WIDTH(1), .SETTLE_CYCLES(2)) dut (
    .clk(clk), .reset(reset), .start(start_a),
    .gate_in1(a_in1), .gate_in0(a_in0), .gate_out(a_out),
    .busy(a_busy), .done(a_done), .pass(a_pass), .err_count(a_err),
    .first_err_vec(a_fvec), .first_err_valid(a_fvalid)
  );

  nand2_sweep_ctrl #(.WIDTH(4), .SETTLE_CYCLES(0)) dut_wide (
    .clk(clk), .reset(reset), .start(start_b),
    .gate_in1(b_in1), .gate_in0(b_in0), .gate_out(b_out),
    .busy(b_busy), .done(b_done), .pass(b_pass), .err_count(b_err),
    .first_err_vec(b_fvec), .first_err_valid(b_fvalid)
  );

  // Behavioural gates under test
  always_comb begin
    case (mode_a)
      0:       a_out = ~(a_in1 & a_in0);
      1:       a_out = 1'b1;
      2:       a_out = a_in1 & a_in0;
      default: a_out = ~(a_in1 & a_in0) ^ flip_a[{a_in1, a_in0}];
    endcase
  end

  always_comb begin
    case (mode_b)
      0:       b_out = ~(b_in1 & b_in0);
      1:       b_out = 4'hF;
      2:       b_out = b_in1 & b_in0;
      default: b_out = ~(b_in1 & b_in0) ^ flip_b[{b_in1, b_in0}];
    endcase
  end

  task automatic snapshot(input int which);
    if (which == 0) begin
      o_vec = {6'd0, a_in1, a_in0}; o_err = a_err; o_fvec = {6'd0, a_fvec};
      o_busy = a_busy; o_done = a_done; o_pass = a_pass; o_fvalid = a_fvalid;
    end else begin
      o_vec = {b_in1, b_in0}; o_err = b_err; o_fvec = b_fvec;
      o_busy = b_busy; o_done = b_done; o_pass = b_pass; o_fvalid = b_fvalid;
    end
  endtask

  task automatic set_start(input int which, input logic v);
    if (which == 0) start_a = v; else start_b = v;
  endtask

  // Reference model: enumerate all vectors, compare the gate's answer
  // with the ideal NAND, count saturating at 255 and remember the first.
  function automatic void model(input int which, output int cnt,
                                output int first, output bit fv);
    int w, n, mask, mode, in1, in0, nand_v, g;
    w = (which == 0) ? 1 : 4;
    n = 1 << (2 * w);
    mask = (1 << w) - 1;
    mode = (which == 0) ? mode_a : mode_b;
    cnt = 0; first = 0; fv = 1'b0;
    for (int v = 0; v < n; v++) begin
      in1 = (v >> w) & mask;
      in0 = v & mask;
      nand_v = ~(in1 & in0) & mask;
      case (mode)
        0:       g = nand_v;
        1:       g = mask;
        2:       g = in1 & in0;
        default: g = nand_v ^ ((which == 0) ? int'(flip_a[v]) : int'(flip_b[v]));
      endcase
      if (g != nand_v) begin
        if (cnt < 255) cnt++;
        if (!fv) begin fv = 1'b1; first = v; end
      end
    end
  endfunction

  // Runs one full sweep from a start pulse, checking the vector schedule
  // every cycle and the final results. Optionally pulses start during the
  // first SETTLE cycle of vector 2 (ignored by the DUT).
  task automatic run_sweep(input int which, input string name, input bit pulse_mid);
    int s, n, total, cnt, first;
    bit fv;
    s = (which == 0) ? 2 : 0;
    n = (which == 0) ? 4 : 256;
    total = n * (s + 2);
    model(which, cnt, first, fv);

    @(negedge clk);
    set_start(which, 1'b1);
    @(negedge clk);
    set_start(which, 1'b0);
    snapshot(which);
    checks++;
    if (o_done !== 1'b0 || o_pass !== 1'b0 || o_err !== 8'd0 ||
        o_fvalid !== 1'b0 || o_busy !== 1'b1) begin
      failures++;
      $display("[TB] FAIL %s.start_clear got done=%b pass=%b err=%0d fv=%b busy=%b exp 0 0 0 0 1",
               name, o_done, o_pass, o_err, o_fvalid, o_busy);
    end
    for (int k = 0; k < total; k++) begin
      snapshot(which);
      checks++;
      if (o_vec !== 8'(k / (s + 2)) || o_busy !== 1'b1 || o_done !== 1'b0) begin
        failures++;
        $display("[TB] FAIL %s.schedule k=%0d got vec=%0h busy=%b done=%b exp vec=%0h busy=1 done=0",
                 name, k, o_vec, o_busy, o_done, k / (s + 2));
      end
      set_start(which, (pulse_mid && k == 2 * (s + 2) + 1) ? 1'b1 : 1'b0);
      @(negedge clk);
    end
    set_start(which, 1'b0);
    snapshot(which);
    checks++;
    if (o_done !== 1'b1 || o_busy !== 1'b0) begin
      failures++;
      $display("[TB] FAIL %s.done_time got done=%b busy=%b exp done=1 busy=0", name, o_done, o_busy);
    end
    checks++;
    if (o_err !== 8'(cnt) || o_pass !== (cnt == 0) || o_fvalid !== fv) begin
      failures++;
      $display("[TB] FAIL %s.result got err=%0d pass=%b fv=%b exp err=%0d pass=%b fv=%b",
               name, o_err, o_pass, o_fvalid, cnt, cnt == 0, fv);
    end
    checks++;
    if (fv && o_fvec !== 8'(first)) begin
      failures++;
      $display("[TB] FAIL %s.first_vec got %0h exp %0h", name, o_fvec, first);
    end
    checks++;
    if (o_vec !== 8'(n - 1)) begin
      failures++;
      $display("[TB] FAIL %s.last_vec got %0h exp %0h", name, o_vec, n - 1);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; start_a = 1'b0; start_b = 1'b0; mode_a = 0; mode_b = 0;
    repeat (2) @(negedge clk);
    checks++;
    if ({a_in1, a_in0, a_busy, a_done, a_pass, a_err, a_fvec, a_fvalid} !== '0 ||
        {b_in1, b_in0, b_busy, b_done, b_pass, b_err, b_fvec, b_fvalid} !== '0) begin
      failures++;
      $display("[TB] FAIL reset_state got a_err=%0d a_busy=%b b_err=%0d b_busy=%b exp all zero",
               a_err, a_busy, b_err, b_busy);
    end
    reset = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if (a_busy !== 1'b0 || a_done !== 1'b0 || b_busy !== 1'b0 || b_done !== 1'b0) begin
      failures++;
      $display("[TB] FAIL idle_hold got a_busy=%b a_done=%b b_busy=%b b_done=%b exp 0",
               a_busy, a_done, b_busy, b_done);
    end
  endtask

  task automatic test_narrow_modes();
    mode_a = 0; run_sweep(0, "nand_ok", 1'b0);
    mode_a = 1; run_sweep(0, "stuck1", 1'b0);
    mode_a = 2; run_sweep(0, "and_gut", 1'b0);
  endtask

  task automatic test_done_hold_restart();
    repeat (4) @(negedge clk);
    checks++;
    if (a_done !== 1'b1 || a_err !== 8'd4 || a_pass !== 1'b0 || a_busy !== 1'b0) begin
      failures++;
      $display("[TB] FAIL done_hold got done=%b err=%0d pass=%b busy=%b exp 1 4 0 0",
               a_done, a_err, a_pass, a_busy);
    end
    mode_a = 0;
    run_sweep(0, "restart", 1'b0);
  endtask

  task automatic test_start_while_busy();
    mode_a = 1;
    run_sweep(0, "busy_start", 1'b1);
  endtask

  task automatic test_reset_mid();
    mode_a = 2;
    @(negedge clk);
    start_a = 1'b1;
    @(negedge clk);
    start_a = 1'b0;
    repeat (7) @(negedge clk);
    checks++;
    if (a_err !== 8'd1 || a_busy !== 1'b1) begin
      failures++;
      $display("[TB] FAIL pre_reset got err=%0d busy=%b exp 1 1", a_err, a_busy);
    end
    #2 reset = 1'b1;
    #1;
    checks++;
    if ({a_in1, a_in0, a_busy, a_done, a_pass, a_err, a_fvec, a_fvalid} !== '0) begin
      failures++;
      $display("[TB] FAIL mid_reset got in=%b%b busy=%b err=%0d fv=%b exp all zero",
               a_in1, a_in0, a_busy, a_err, a_fvalid);
    end
    @(negedge clk);
    reset = 1'b0;
    mode_a = 0;
    run_sweep(0, "post_reset", 1'b0);
  endtask

  task automatic test_random();
    mode_a = 3;
    for (int it = 0; it < 6; it++) begin
      for (int v = 0; v < 4; v++) flip_a[v] = 1'($urandom_range(0, 1));
      run_sweep(0, "rand_narrow", 1'b0);
    end
  endtask

  task automatic test_wide();
    mode_b = 2;
    run_sweep(1, "wide_and", 1'b0);
    mode_b = 3;
    for (int v = 0; v < 256; v++)
      flip_b[v] = ($urandom_range(0, 7) == 0) ? 4'($urandom_range(1, 15)) : 4'd0;
    run_sweep(1, "wide_rand", 1'b0);
  endtask

  initial begin
    for (int v = 0; v < 4; v++) flip_a[v] = 1'b0;
    for (int v = 0; v < 256; v++) flip_b[v] = 4'd0;
    test_reset();
    test_narrow_modes();
    test_done_hold_restart();
    test_start_while_busy();
    test_reset_mid();
    test_random();
    test_wide();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
